// File: rtl/lights_led_sequencer.sv
// LED sequencer: Avalon-MM master that streams rotate/table patterns to a PIO.
// Define LED_SEQ_BOUNCE_EN for ping-pong table walks and reversing rotation.
module lights_led_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TABLE_DEPTH    = 8,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        step
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PRESCALE_WIDTH;
  localparam int IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic            run_q;
  logic            mode_q;
  logic [IW-1:0]   last_q;
  logic [PW-1:0]   period_q;
  logic [IW-1:0]   tidx_q;
  logic [DW-1:0]   tbl_q [TABLE_DEPTH];
  logic [DW-1:0]   pattern_q;
  logic [DW-1:0]   wdata_q;
  logic [IW-1:0]   index_q;
  logic [PW-1:0]   cnt_q;
  logic [DW-1:0]   pat_d;
  logic [IW-1:0]   idx_d;
`ifdef LED_SEQ_BOUNCE_EN
  logic            dir_q;
  logic            dir_d;
`endif

  logic wr;
  logic unused_wd;

  assign wr        = s_chipselect & ~s_write_n;
  assign unused_wd = ^s_writedata;

  assign m_address    = 2'b00;
  assign m_chipselect = (state_q == S_WRITE);
  assign m_write_n    = ~m_chipselect;
  assign m_writedata  = {{(32-DW){1'b0}}, wdata_q};
  assign step         = m_chipselect & ~m_waitrequest;

  // Next pattern/index, applied only when a PIO write is accepted
  always_comb begin
    pat_d = pattern_q;
    idx_d = index_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d = dir_q;
`endif
    if (mode_q) begin
`ifdef LED_SEQ_BOUNCE_EN
      if (!dir_q) begin
        if (index_q >= last_q) begin
          idx_d = (last_q == '0) ? '0 : index_q - 1'b1;
          dir_d = (last_q != '0);
        end else begin
          idx_d = index_q + 1'b1;
        end
      end else if (index_q == '0) begin
        idx_d = (last_q == '0) ? '0 : IW'(1);
        dir_d = 1'b0;
      end else begin
        idx_d = index_q - 1'b1;
      end
`else
      idx_d = (index_q == last_q) ? '0 : index_q + 1'b1;
`endif
      pat_d = tbl_q[idx_d];
    end else begin
`ifdef LED_SEQ_BOUNCE_EN
      if (dir_q) begin
        pat_d = {pattern_q[0], pattern_q[DW-1:1]};
        if (pat_d[0]) dir_d = 1'b0;
      end else begin
        pat_d = {pattern_q[DW-2:0], pattern_q[DW-1]};
        if (pat_d[DW-1]) dir_d = 1'b1;
      end
`else
      pat_d = {pattern_q[DW-2:0], pattern_q[DW-1]};
`endif
    end
  end

  always_comb begin
    s_readdata = '0;
    unique case (s_address)
      2'd0: begin
        s_readdata[0]         = run_q;
        s_readdata[1]         = mode_q;
        s_readdata[2 +: IW]   = last_q;
        s_readdata[2+IW +: IW] = index_q;
`ifdef LED_SEQ_BOUNCE_EN
        s_readdata[31]        = dir_q;
`endif
      end
      2'd1: s_readdata[PW-1:0] = period_q;
      2'd2: s_readdata[IW-1:0] = tidx_q;
      2'd3: s_readdata[DW-1:0] = pattern_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      mode_q    <= 1'b0;
      last_q    <= '0;
      period_q  <= '0;
      tidx_q    <= '0;
      pattern_q <= '0;
      wdata_q   <= '0;
      index_q   <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < TABLE_DEPTH; i++) tbl_q[i] <= '0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      if (wr) begin
        unique case (s_address)
          2'd0: begin
            run_q  <= s_writedata[0];
            mode_q <= s_writedata[1];
            last_q <= s_writedata[2 +: IW];
          end
          2'd1: period_q <= s_writedata[PW-1:0];
          2'd2: tidx_q   <= s_writedata[IW-1:0];
          2'd3: begin
            tbl_q[tidx_q] <= s_writedata[DW-1:0];
            tidx_q        <= tidx_q + 1'b1;
          end
        endcase
      end
      unique case (state_q)
        S_IDLE: begin
          if (run_q) begin
            pattern_q <= tbl_q[0];
            wdata_q   <= tbl_q[0];
            index_q   <= '0;
`ifdef LED_SEQ_BOUNCE_EN
            dir_q     <= 1'b0;
`endif
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!m_waitrequest) begin
            pattern_q <= pat_d;
            index_q   <= idx_d;
`ifdef LED_SEQ_BOUNCE_EN
            dir_q     <= dir_d;
`endif
            if (!run_q) begin
              state_q <= S_IDLE;
            end else if (period_q == '0) begin
              wdata_q <= pat_d;
            end else begin
              cnt_q   <= period_q - 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!run_q) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            wdata_q <= pattern_q;
            state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lights_led_sequencer.sv
// Directed bench for lights_led_sequencer with a PIO-write scoreboard.
// Expectations follow LED_SEQ_BOUNCE_EN when it is defined.
module tb_lights_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        step;

  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          last_step = -1;
  int          gap_exp = 0;
  logic [7:0]  expq[$];

  lights_led_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_write_n     (s_write_n),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .step          (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc_n++;
    if (m_chipselect && !m_write_n) begin
      chk("m_address", {30'b0, m_address}, 32'd0);
      if (m_waitrequest) begin
        chk("stall_step", {31'b0, step}, 32'd0);
        if (expq.size() != 0)
          chk("stall_data", m_writedata, {24'b0, expq[0]});
      end else begin
        chk("step_pulse", {31'b0, step}, 32'd1);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL extra_write observed=%h expected=none", m_writedata);
        end else begin
          e = expq.pop_front();
          chk("wdata", m_writedata, {24'b0, e});
          if (last_step >= 0)
            chk("step_gap", 32'(cyc_n - last_step), 32'(gap_exp));
          last_step = cyc_n;
        end
      end
    end else begin
      chk("step_idle", {31'b0, step}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic swr(input logic [1:0] a, input logic [31:0] d);
    s_address    = a;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    s_writedata  = d;
    tick();
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_writedata  = '0;
  endtask

  task automatic srd(input logic [1:0] a, input logic [31:0] exp,
                     input string tag);
    s_address = a;
    #1;
    chk(tag, s_readdata, exp);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && expq.size() != 0; i++) tick();
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    s_address     = '0;
    s_chipselect  = 1'b0;
    s_write_n     = 1'b1;
    s_writedata   = '0;
    m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'b0, m_chipselect}, 32'd0);
    chk("rst_wn", {31'b0, m_write_n}, 32'd1);
    chk("rst_wdata", m_writedata, 32'd0);
    chk("rst_step", {31'b0, step}, 32'd0);
    for (int a = 0; a < 4; a++) srd(2'(a), 32'd0, "rst_rd");
    reset = 1'b0;
    repeat (3) tick();

    // rotate, PERIOD=3
    gap_exp = 4;
    last_step = -1;
    swr(2'd2, 32'd0);
    swr(2'd3, 32'h01);
    swr(2'd1, 32'd3);
    srd(2'd1, 32'd3, "period_rd");
    srd(2'd3, 32'd0, "pattern_rd_idle");
    expq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`ifdef LED_SEQ_BOUNCE_EN
    expq.push_back(8'h40);
`else
    expq.push_back(8'h01);
`endif
    swr(2'd0, 32'h1);
    srd(2'd0, 32'h1, "ctrl_rd_rot");
    drain("rot_drain");
    swr(2'd0, 32'h0);
    repeat (6) tick();
`ifdef LED_SEQ_BOUNCE_EN
    chk("rot_hold", m_writedata, 32'h40);
`else
    chk("rot_hold", m_writedata, 32'h01);
`endif

    // table, L=2, PERIOD=0, run cleared mid-stream
    gap_exp = 1;
    last_step = -1;
    swr(2'd2, 32'd0);
    swr(2'd3, 32'hAA);
    swr(2'd3, 32'h55);
    swr(2'd3, 32'hF0);
    srd(2'd2, 32'd3, "tidx_rd");
    swr(2'd1, 32'd0);
`ifdef LED_SEQ_BOUNCE_EN
    expq = '{8'hAA, 8'h55, 8'hF0, 8'h55, 8'hAA};
`else
    expq = '{8'hAA, 8'h55, 8'hF0, 8'hAA, 8'h55};
`endif
    swr(2'd0, 32'hB);
    srd(2'd0, 32'hB, "ctrl_rd_tbl");
    repeat (4) tick();
    swr(2'd0, 32'h0);
    repeat (6) tick();
    chk("tbl_count", 32'(expq.size()), 32'd0);
    chk("tbl_idle_cs", {31'b0, m_chipselect}, 32'd0);

    // waitrequest stall for 5 cycles on the first write
    gap_exp = 3;
    last_step = -1;
    swr(2'd2, 32'd0);
    swr(2'd3, 32'h03);
    swr(2'd1, 32'd2);
    expq = '{8'h03, 8'h06, 8'h0C};
    m_waitrequest = 1'b1;
    swr(2'd0, 32'h1);
    repeat (6) tick();
    m_waitrequest = 1'b0;
    drain("stall_drain");
    swr(2'd0, 32'h0);
    repeat (5) tick();
    chk("stall_hold", m_writedata, 32'h0C);

    // table 1,2,3,4 with L=3
    gap_exp = 3;
    last_step = -1;
    swr(2'd2, 32'd0);
    for (int k = 1; k <= 4; k++) swr(2'd3, 32'(k));
    swr(2'd1, 32'd2);
`ifdef LED_SEQ_BOUNCE_EN
    expq = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h3, 8'h2, 8'h1, 8'h2};
`else
    expq = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h1, 8'h2, 8'h3, 8'h4};
`endif
    swr(2'd0, 32'hF);
    drain("walk_drain");
    swr(2'd0, 32'h0);
    repeat (5) tick();

    // reset while a write is on the bus
    swr(2'd0, 32'hF);
    tick();
    chk("pre_rst_cs", {31'b0, m_chipselect}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", {31'b0, m_chipselect}, 32'd0);
    chk("mid_rst_wn", {31'b0, m_write_n}, 32'd1);
    chk("mid_rst_wdata", m_writedata, 32'd0);
    chk("mid_rst_step", {31'b0, step}, 32'd0);
    srd(2'd0, 32'd0, "mid_rst_ctrl");
    srd(2'd1, 32'd0, "mid_rst_period");
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("post_rst_cs", {31'b0, m_chipselect}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
